// File: rtl/membus_pkg.sv
// Shared m_bus definitions: widths, line geometry and the responder state encoding.
// Widths track Sysbus.defs so cache and memory sides agree.
package membus_pkg;

    localparam int MB_DATA_W     = 64;
    localparam int MB_TAG_W      = 13;
    localparam int MB_BEATS      = 8;
    localparam int MB_LINE_BYTES = MB_BEATS * MB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT,
        SEND
    } mb_state_e;

endpackage

// File: rtl/dram_word_array.sv
// Backing store for the responder: synchronous write, asynchronous read, contents survive reset.
module dram_word_array #(
    parameter int  WORDS  = 1024,
    parameter int  DATA_W = 64,
    localparam int AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dram_responder.sv
// Memory end of the m_bus line fill: ack one request, wait a fixed latency,
// then stream one line of beats in ascending word order, one beat per respack.
module dram_responder
    import membus_pkg::*;
#(
    parameter int  BUS_DATA_WIDTH = MB_DATA_W,
    parameter int  BUS_TAG_WIDTH  = MB_TAG_W,
    parameter int  MEM_WORDS      = 1024,
    parameter int  BEATS          = MB_BEATS,
    parameter int  LATENCY        = 4,
    localparam int AW             = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      ld_en,
    input  logic [AW-1:0]             ld_addr,
    input  logic [BUS_DATA_WIDTH-1:0] ld_data
);

    localparam int PW   = $clog2(BEATS);
    localparam int CW   = $clog2(LATENCY) + 1;
    localparam int BOFF = $clog2(BUS_DATA_WIDTH / 8);

    mb_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [AW-1:0]            base_q, base_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                     reqack_q, reqack_d;

    logic [AW-1:0]             req_word;
    logic [AW-1:0]             rd_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                      unused_req_bits;

    // Byte offset inside a beat and address bits above the array are don't-care.
    assign req_word        = bus_req[BOFF +: AW];
    assign unused_req_bits = ^{bus_req[BUS_DATA_WIDTH-1:BOFF+AW], bus_req[BOFF-1:0]};
    assign rd_addr         = base_q + AW'(ptr_q);

    dram_word_array #(
        .WORDS  (MEM_WORDS),
        .DATA_W (BUS_DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        base_d   = base_q;
        tag_d    = tag_q;
        reqack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus_reqcyc) begin
                    base_d   = req_word & ~AW'(BEATS - 1);
                    tag_d    = bus_reqtag;
                    reqack_d = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    ptr_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SEND: begin
                if (bus_respack) begin
                    if (ptr_q == PW'(BEATS - 1)) begin
                        ptr_d   = '0;
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            base_q   <= '0;
            tag_q    <= '0;
            reqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            base_q   <= base_d;
            tag_q    <= tag_d;
            reqack_q <= reqack_d;
        end
    end

    // Beat outputs decode straight from state so an async reset clears them at once.
    assign bus_reqack  = reqack_q;
    assign bus_respcyc = (state_q == SEND);
    assign bus_resp    = (state_q == SEND) ? rd_data : '0;
    assign bus_resptag = (state_q == SEND) ? tag_q : '0;

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: stimulus pushes expected beats as it acks them,
// a negedge monitor pops and compares every consumed beat and watches hold/ack rules.
module tb_dram_responder;

    localparam int W   = 1024;
    localparam int LAT = 4;
    localparam int NB  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_reqcyc = 1'b0;
    logic        bus_reqack;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respcyc;
    logic        bus_respack = 1'b0;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;

    dram_responder dut (
        .clk         (clk),
        .reset       (rst_n),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [12:0] tag;
    } beat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ack_count = 0;
    logic [63:0] model [W];
    beat_t       exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor
    logic        prev_cyc = 1'b0, prev_ack = 1'b0, prev_ld = 1'b0, prev_reqack = 1'b0;
    logic [63:0] prev_resp = '0;
    logic [12:0] prev_tag = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cyc    = 1'b0;
            prev_reqack = 1'b0;
        end else begin
            if (bus_reqack) begin
                ack_count++;
                check("reqack_single_cycle", 64'(prev_reqack), 64'd0);
            end
            if (prev_cyc && !prev_ack) begin
                check("respcyc_held", 64'(bus_respcyc), 64'd1);
                if (!prev_ld) begin
                    check("resp_stable", bus_resp, prev_resp);
                    check("resptag_stable", 64'(bus_resptag), 64'(prev_tag));
                end
            end
            if (bus_respcyc && bus_respack) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_beat: got %h expected none", bus_resp);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", bus_resp, e.data);
                    check("beat_tag", 64'(bus_resptag), 64'(e.tag));
                end
            end
            prev_cyc    = bus_respcyc;
            prev_reqack = bus_reqack;
        end
        prev_ack  = bus_respack;
        prev_ld   = ld_en;
        prev_resp = bus_resp;
        prev_tag  = bus_resptag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request, check ack comes next cycle and first beat LAT+1 cycles after the ack.
    task automatic issue_req(input logic [63:0] addr, input logic [12:0] tag, input bit spur);
        int k;
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus_reqack && k < 20);
        check("reqack_latency", 64'(k), 64'd1);
        if (spur) begin
            bus_reqtag = 13'h1FFF;
            bus_req    = 64'h200;
        end else begin
            bus_reqcyc = 1'b0;
        end
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus_respcyc && k < 20);
        check("first_beat_latency", 64'(k), 64'(LAT + 1));
    endtask

    task automatic serve_beats(input int base, input logic [12:0] tag,
                               input int hold_beat, input int hold_n,
                               input int ld_beat, input bit trail);
        for (int i = 0; i < NB; i++) begin
            int w;
            w = (base + i) % W;
            check("respcyc_on", 64'(bus_respcyc), 64'd1);
            if (i == hold_beat) begin
                bus_respack = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    check("held_data", bus_resp, model[w]);
                    tick();
                end
            end
            if (i == ld_beat) begin
                bus_respack = 1'b0;
                check("pre_ld_data", bus_resp, model[w]);
                ld_en    = 1'b1;
                ld_addr  = 10'(w);
                ld_data  = 64'hDEAD_BEEF_0000_0000 | 64'(w);
                model[w] = 64'hDEAD_BEEF_0000_0000 | 64'(w);
                tick();
                ld_en = 1'b0;
                check("ld_visible", bus_resp, model[w]);
            end
            if (i == NB - 1) bus_reqcyc = 1'b0;
            exp_q.push_back('{data: model[w], tag: tag});
            bus_respack = 1'b1;
            tick();
        end
        if (trail) tick();
        bus_respack = 1'b0;
        check("respcyc_off", 64'(bus_respcyc), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;

        // Preload under reset through the backdoor, then check reset outputs
        for (int i = 0; i < W; i++) begin
            model[i] = 64'h1000 + 64'(i);
            ld_en    = 1'b1;
            ld_addr  = 10'(i);
            ld_data  = 64'h1000 + 64'(i);
            tick();
        end
        ld_en = 1'b0;
        check("rst_reqack", 64'(bus_reqack), 64'd0);
        check("rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_resp", bus_resp, 64'd0);
        check("rst_resptag", 64'(bus_resptag), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: aligned line at word 8
        issue_req(64'h40, 13'h5, 1'b0);
        check("t1_first_beat", bus_resp, 64'h1008);
        serve_beats(8, 13'h5, -1, 0, -1, 1'b0);

        // 2: unaligned address, same line as 0x78
        issue_req(64'h7F, 13'h0A3, 1'b0);
        check("t2_first_beat", bus_resp, 64'h1008);
        serve_beats(8, 13'h0A3, -1, 0, -1, 1'b0);

        // 3: respack withheld on beat 2
        issue_req(64'h80, 13'h1ABC, 1'b0);
        serve_beats(16, 13'h1ABC, 2, 3, -1, 1'b0);

        // 4: spurious reqcyc during WAIT/SEND and trailing respack
        acks0 = ack_count;
        issue_req(64'h100, 13'h0777, 1'b1);
        serve_beats(32, 13'h0777, -1, 0, -1, 1'b1);
        repeat (3) tick();
        check("t4_ack_count", 64'(ack_count - acks0), 64'd1);
        check("t4_idle_respcyc", 64'(bus_respcyc), 64'd0);
        issue_req(64'h140, 13'h0042, 1'b0);
        serve_beats(40, 13'h0042, -1, 0, -1, 1'b0);

        // 5: reset in the middle of beat 4, array retained afterwards
        issue_req(64'hC0, 13'h0123, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{data: model[24 + i], tag: 13'h0123});
            bus_respack = 1'b1;
            tick();
        end
        bus_respack = 1'b0;
        check("t5_beat4_before_rst", bus_resp, 64'h101C);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("t5_rst_resp", bus_resp, 64'd0);
        check("t5_rst_resptag", 64'(bus_resptag), 64'd0);
        check("t5_sb_drained", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        issue_req(64'h0, 13'h0010, 1'b0);
        check("t5_word0", bus_resp, 64'h1000);
        serve_beats(0, 13'h0010, -1, 0, -1, 1'b0);

        // 6: top line (address also beyond the array), backdoor rewrite, back-to-back requests
        acks0 = ack_count;
        issue_req(64'h3FC0, 13'h0ACE, 1'b0);
        check("t6_first_beat", bus_resp, 64'h13F8);
        serve_beats(1016, 13'h0ACE, -1, 0, 3, 1'b0);
        issue_req(64'h1FC0, 13'h0BEE, 1'b0);
        check("t6_rewritten_kept", 64'(model[1019]), 64'hDEAD_BEEF_0000_03FB);
        serve_beats(1016, 13'h0BEE, -1, 0, -1, 1'b0);
        repeat (2) tick();
        check("t6_ack_count", 64'(ack_count - acks0), 64'd2);
        check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
